// File: rtl/veldt_data_ram_if.sv
// veldt_data_ram_if
//   Request/response bundle between the Veldt core and its data memory.
//   Signals:
//     ramIn  [96:0]  request from the core: {we, byte address, write data, bit mask}
//     ramOut [31:0]  registered read data returned by the memory
//     ready          memory is initialised and servicing requests
//     fault          the previous-cycle write targeted an out-of-range address
//   Modports:
//     master  core side (drives ramIn)
//     slave   memory side (drives ramOut, ready, fault)
interface veldt_data_ram_if;
    logic [96:0] ramIn;
    logic [31:0] ramOut;
    logic        ready;
    logic        fault;

    modport master (output ramIn, input ramOut, input ready, input fault);
    modport slave  (input ramIn, output ramOut, output ready, output fault);
endinterface

// File: rtl/veldt_data_ram.sv
// veldt_data_ram
//   Word-addressed 32-bit data memory for the Veldt core. Every RUN cycle is a
//   request: the addressed word is read (pre-write contents) and returned on
//   ramOut one cycle later, and an optional bit-masked write is applied.
//   After reset the array is optionally zero-filled (DEPTH cycles) before
//   ready rises. Writes outside [BASE, BASE + 4*DEPTH) are dropped and flagged
//   on fault the following cycle; out-of-range reads return 0.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous, active-high
//     bus    slave side of veldt_data_ram_if (ramIn in; ramOut/ready/fault out)
//   Parameters:
//     DEPTH           number of 32-bit words (power of two, >= 2)
//     BASE            byte address of word 0 (4-byte aligned)
//     CLEAR_ON_RESET  1 = zero-fill after reset, 0 = enter RUN immediately
module veldt_data_ram #(
    parameter int          DEPTH          = 1024,
    parameter logic [31:0] BASE           = 32'h0000_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    veldt_data_ram_if.slave  bus
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [31:0]     ramout_q, ramout_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;

    logic [31:0]     mem [DEPTH];

    // Request decode
    logic            req_we;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic [31:0]     req_mask;
    assign {req_we, req_addr, req_wdata, req_mask} = bus.ramIn;

    // Offset is formed in 33 bits so an address below BASE cannot wrap into
    // a legal offset; the explicit addr >= BASE check rejects it as well.
    logic [32:0]     off;
    logic            inrange;
    logic [AW-1:0]   idx;
    logic [31:0]     rd_word;

    assign off     = {1'b0, req_addr} - {1'b0, BASE};
    assign inrange = (req_addr >= BASE) && (off < SPAN);
    assign idx     = off[AW+1:2];
    assign rd_word = mem[idx];

    // Single array write port shared by the zero-fill and user writes
    logic            mem_we;
    logic [AW-1:0]   mem_widx;
    logic [31:0]     mem_wdata;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ramout_d  = 32'h0;
        fault_d   = 1'b0;
        mem_we    = 1'b0;
        mem_widx  = idx;
        mem_wdata = (rd_word & ~req_mask) | (req_wdata & req_mask);

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                mem_wdata = 32'h0;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // rd_word is the pre-write contents: read-before-write
                ramout_d = inrange ? rd_word : 32'h0;
                fault_d  = req_we && !inrange;
                mem_we   = req_we && inrange;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Nothing reaches the array on a reset cycle, fill or user write alike
        if (reset) begin
            mem_we = 1'b0;
        end

        ready_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_idx_q <= '0;
            ramout_q  <= 32'h0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ramout_q  <= ramout_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign bus.ramOut = ramout_q;
    assign bus.ready  = ready_q;
    assign bus.fault  = fault_q;

endmodule

// File: tb/tb_veldt_data_ram.sv
// tb_veldt_data_ram
//   Three DEPTH=16 instances: A (BASE 0, zero-fill), B (BASE 0x1000, zero-fill),
//   C (BASE 0, no fill). A per-instance reference model tracks fill progress,
//   array contents and expected outputs; a negedge process compares every
//   instance against it each cycle, and directed steps add literal checks.
module tb_veldt_data_ram;

    localparam int MD = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst;
    logic [2:0]  we;
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic [31:0] mk   [3];

    int n_tests = 0;
    int n_fail  = 0;

    veldt_data_ram_if bus_a ();
    veldt_data_ram_if bus_b ();
    veldt_data_ram_if bus_c ();

    assign bus_a.ramIn = {we[0], addr[0], wd[0], mk[0]};
    assign bus_b.ramIn = {we[1], addr[1], wd[1], mk[1]};
    assign bus_c.ramIn = {we[2], addr[2], wd[2], mk[2]};

    veldt_data_ram #(.DEPTH(MD), .BASE(32'h0000_0000), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clock(clk), .reset(rst[0]), .bus(bus_a));
    veldt_data_ram #(.DEPTH(MD), .BASE(32'h0000_1000), .CLEAR_ON_RESET(1'b1)) dut_b (
        .clock(clk), .reset(rst[1]), .bus(bus_b));
    veldt_data_ram #(.DEPTH(MD), .BASE(32'h0000_0000), .CLEAR_ON_RESET(1'b0)) dut_c (
        .clock(clk), .reset(rst[2]), .bus(bus_c));

    logic [31:0] act_out [3];
    logic        act_rdy [3];
    logic        act_flt [3];
    assign act_out[0] = bus_a.ramOut;  assign act_rdy[0] = bus_a.ready;  assign act_flt[0] = bus_a.fault;
    assign act_out[1] = bus_b.ramOut;  assign act_rdy[1] = bus_b.ready;  assign act_flt[1] = bus_b.fault;
    assign act_out[2] = bus_c.ramOut;  assign act_rdy[2] = bus_c.ready;  assign act_flt[2] = bus_c.fault;

    function automatic logic [31:0] base_of(int k);
        return (k == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic bit clr_of(int k);
        return (k != 2);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mmem [3][MD];   // starts as X: unknown contents
    int          fill    [3];    // fill cycles completed since reset
    logic [31:0] e_out   [3];
    logic        e_rdy   [3];
    logic        e_flt   [3];
    bit          started [3];

    task automatic model_edge(int k);
        longint o;
        int     i;
        bit     inr;
        bit     running;
        if (rst[k]) begin
            fill[k]    = 0;
            e_out[k]   = 32'h0;
            e_rdy[k]   = 1'b0;
            e_flt[k]   = 1'b0;
            started[k] = 1'b1;
        end else if (started[k]) begin
            running = !clr_of(k) || (fill[k] >= MD);
            if (!running) begin
                fill[k]++;
                e_out[k] = 32'h0;
                e_flt[k] = 1'b0;
                if (fill[k] == MD) begin
                    for (int j = 0; j < MD; j++) mmem[k][j] = 32'h0;
                end
                e_rdy[k] = (fill[k] >= MD);
            end else begin
                o   = longint'(addr[k]) - longint'(base_of(k));
                inr = (o >= 0) && (o < MD * 4);
                i   = inr ? int'(o / 4) : 0;
                e_out[k] = inr ? mmem[k][i] : 32'h0;
                e_flt[k] = we[k] && !inr;
                if (we[k] && inr)
                    mmem[k][i] = (mmem[k][i] & ~mk[k]) | (wd[k] & mk[k]);
                e_rdy[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_edge(k);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (started[k]) begin
                chk($sformatf("m%0d_ready", k), 32'(act_rdy[k]), 32'(e_rdy[k]));
                chk($sformatf("m%0d_fault", k), 32'(act_flt[k]), 32'(e_flt[k]));
                if (!$isunknown(e_out[k]))
                    chk($sformatf("m%0d_ramout", k), act_out[k], e_out[k]);
            end
        end
    end

    // One request cycle on instance k; on return the response is on the outputs.
    task automatic go(int k, bit w, logic [31:0] a, logic [31:0] d, logic [31:0] m);
        we[k] = w; addr[k] = a; wd[k] = d; mk[k] = m;
        $display("[TB] dut%0d rst=%0d we=%0d addr=%h wdata=%h mask=%h", k, rst[k], w, a, d, m);
        @(negedge clk);
        we[k] = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 3'b111;
        we  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            addr[k] = 32'h0; wd[k] = 32'h0; mk[k] = 32'h0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready_a", 32'(act_rdy[0]), 32'd0);
        chk("reset_ramout_a", act_out[0], 32'h0);
        rst = 3'b000;

        // Fill takes DEPTH edges after reset deasserts; C is ready at once
        for (int i = 1; i <= MD; i++) begin
            @(negedge clk);
            chk($sformatf("fill_ready_a_%0d", i), 32'(act_rdy[0]), (i == MD) ? 32'd1 : 32'd0);
            if (i == 1) chk("noclr_ready_c", 32'(act_rdy[2]), 32'd1);
        end

        for (int a = 0; a < 64; a += 4) begin
            go(0, 1'b0, 32'(a), 32'h0, 32'h0);
            chk("clear_read_a", act_out[0], 32'h0);
        end

        // Full write then read-back; write cycle returns old contents
        go(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFF_FFFF);
        chk("wr_cycle_old_a", act_out[0], 32'h0);
        go(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("rd_full_a", act_out[0], 32'hDEADBEEF);
        chk("model_pin_full", e_out[0], 32'hDEADBEEF);

        // Partial mask, then zero mask
        go(0, 1'b1, 32'h10, 32'h0000_0012, 32'h0000_00FF);
        go(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("rd_partial_a", act_out[0], 32'hDEADBE12);
        chk("model_pin_partial", e_out[0], 32'hDEADBE12);
        go(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h0);
        go(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("rd_mask0_a", act_out[0], 32'hDEADBE12);

        // addr[1:0] ignored
        go(0, 1'b1, 32'h13, 32'h0000_0055, 32'hFFFF_FFFF);
        go(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("rd_alias_a", act_out[0], 32'h0000_0055);

        // Back-to-back writes to one word
        go(0, 1'b1, 32'h20, 32'h0000_0001, 32'hFFFF_FFFF);
        go(0, 1'b1, 32'h20, 32'h0000_0002, 32'hFFFF_FFFF);
        chk("b2b_second_sees_first", act_out[0], 32'h0000_0001);
        go(0, 1'b0, 32'h20, 32'h0, 32'h0);
        chk("b2b_final", act_out[0], 32'h0000_0002);

        // Out of range on A
        go(0, 1'b0, 32'h40, 32'h0, 32'h0);
        chk("oor_read_a", act_out[0], 32'h0);
        chk("oor_read_nofault_a", 32'(act_flt[0]), 32'd0);
        go(0, 1'b1, 32'h40, 32'h1234_5678, 32'hFFFF_FFFF);
        chk("oor_write_fault_a", 32'(act_flt[0]), 32'd1);
        go(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("post_fault_clear_a", 32'(act_flt[0]), 32'd0);
        chk("post_fault_data_a", act_out[0], 32'h0000_0055);

        // Range checks with BASE=0x1000
        go(1, 1'b1, 32'h0FFC, 32'hCAFEF00D, 32'hFFFF_FFFF);
        chk("below_base_fault_b", 32'(act_flt[1]), 32'd1);
        go(1, 1'b1, 32'h1040, 32'hCAFEF00D, 32'hFFFF_FFFF);
        chk("above_top_fault_b", 32'(act_flt[1]), 32'd1);
        go(1, 1'b0, 32'h1040, 32'h0, 32'h0);
        chk("above_top_read_b", act_out[1], 32'h0);
        chk("above_top_read_nofault_b", 32'(act_flt[1]), 32'd0);
        go(1, 1'b0, 32'h103C, 32'h0, 32'h0);
        chk("unchanged_top_b", act_out[1], 32'h0);
        go(1, 1'b0, 32'h1000, 32'h0, 32'h0);
        chk("unchanged_bottom_b", act_out[1], 32'h0);
        go(1, 1'b1, 32'h103C, 32'hAABBCCDD, 32'hFFFF_FFFF);
        chk("top_write_nofault_b", 32'(act_flt[1]), 32'd0);
        go(1, 1'b0, 32'h103C, 32'h0, 32'h0);
        chk("top_read_b", act_out[1], 32'hAABBCCDD);

        // Reset mid-fill on A: fill restarts for a full DEPTH cycles
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("midfill_ready_a", 32'(act_rdy[0]), 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        for (int i = 1; i <= MD; i++) begin
            @(negedge clk);
            chk($sformatf("refill_ready_a_%0d", i), 32'(act_rdy[0]), (i == MD) ? 32'd1 : 32'd0);
        end
        go(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("refill_cleared_a", act_out[0], 32'h0);

        // No-fill instance: write/read, then a write during reset is dropped
        go(2, 1'b1, 32'h08, 32'h1234_5678, 32'hFFFF_FFFF);
        go(2, 1'b0, 32'h08, 32'h0, 32'h0);
        chk("rd_c", act_out[2], 32'h1234_5678);
        rst[2] = 1'b1;
        go(2, 1'b1, 32'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rst[2] = 1'b0;
        chk("reset_ready_c", 32'(act_rdy[2]), 32'd0);
        go(2, 1'b0, 32'h08, 32'h0, 32'h0);
        chk("reset_write_dropped_c", act_out[2], 32'h1234_5678);
        chk("ready_after_reset_c", 32'(act_rdy[2]), 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
